pixel_array_readout: RTL and testbench
======================================

PIXEL_ARRAY_READOUT -- requirements
Module: pixel_array_readout

Interface
REQ-001 Parameter PIX_W, 8, output pixel code width.
REQ-002 Parameter ACC_W, 12, per-pixel charge accumulator width; PIX_W <= ACC_W.
REQ-003 Parameter FIFO_DEPTH, 4, output buffer depth in words; power of two.
REQ-004 clk  in  1  rising-edge clock, 1 cycle = 1 ms exposure unit.
REQ-005 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-006 erase  in  1  clear all pixel charge.
REQ-007 expose  in  1  integrate light into all pixels.
REQ-008 nre1  in  1  row 1 read enable, active-low.
REQ-009 nre2  in  1  row 2 read enable, active-low.
REQ-010 adc  in  1  ADC sample window, active-high.
REQ-011 light  in  4*PIX_W  per-pixel intensity; slice k = pixel k, k = 2*row + col, row/col in {0,1}.
REQ-012 pix_data  out  PIX_W+2  {row, col, code}.
REQ-013 pix_valid  out  1  pix_data holds a word.
REQ-014 pix_ready  in  1  downstream accepts word.
REQ-015 frame_done  out  1  one-cycle pulse, full frame pushed.
REQ-016 overrun  out  1  sticky, a word was dropped.
REQ-017 proto_err  out  1  sticky, illegal control combination seen.

Function
REQ-018 erase=1: all accumulators SHALL be 0 the next cycle; erase has priority over expose.
REQ-019 expose=1, erase=0: each acc[k] SHALL become min(acc[k]+light[k], 2^ACC_W-1) each cycle (saturating, no wrap).
REQ-020 Neither asserted: accumulators SHALL hold.
REQ-021 Pixel code SHALL be acc[k][ACC_W-1 -: PIX_W], sampled on the push cycle.
REQ-022 Sequencer states IDLE, PUSH0, PUSH1; IDLE->PUSH0 on adc rising edge (adc=1, previous adc=0) with exactly one nre low; PUSH0->PUSH1->IDLE unconditionally.
REQ-023 Row latched at the rising edge: nre1=0 -> row 0, nre2=0 -> row 1; PUSH0 pushes col 0, PUSH1 pushes col 1 of that row.
REQ-024 adc rising with both nre high or both low: no push, sequencer stays IDLE.
REQ-025 First push SHALL occur the cycle after the adc rising edge; latency push-to-pix_valid = 1 cycle when FIFO empty.
REQ-026 Output handshake: word transfers when pix_valid & pix_ready; pix_data stable while pix_valid & !pix_ready.
REQ-027 Push when full and no pop that cycle: word dropped, overrun set; push and pop in same cycle when full: both succeed, no overrun.
REQ-028 frame_done SHALL pulse one cycle after row 1 col 1 is pushed (or dropped), once per row-1 read.
REQ-029 adc falling during PUSH0/PUSH1 SHALL NOT abort the sequence.

Reset
REQ-030 On reset: accumulators 0, FIFO empty, pix_valid 0, frame_done 0, overrun 0, proto_err 0, sequencer IDLE, adc history 0.
REQ-031 Reset mid-sequence SHALL discard pending and buffered words; no partial row survives.

Configuration
REQ-032 Macro PIXEL_PROTOCOL_CHECK_EN defined: proto_err set sticky on any of nre1=0&nre2=0, expose&erase, adc=1 with nre1=nre2=1, expose&adc.
REQ-033 Macro undefined: checker absent, proto_err constant 0; all other behaviour identical.

Structure
REQ-034 Package pixel_pkg SHALL hold sequencer state enum, default widths, pixel index constants.
REQ-035 Output buffer SHALL be sub-module readout_fifo (synchronous, depth FIFO_DEPTH, full/empty flags, simultaneous push/pop).

Verification
REQ-036 erase 1 cycle, expose 15 cycles, light all 0x10 -> read row 0 then row 1 -> words {0,0,0x0F},{0,1,0x0F},{1,0,0x0F},{1,1,0x0F}; frame_done pulses once.
REQ-037 light[0]=0xFF, expose 30 cycles -> acc[0]=4095 saturated, code 0xFF, no wrap.
REQ-038 pix_ready=0, read both rows (4 words) then a third row-0 read -> 2 words dropped, overrun=1; release ready -> first 4 words out in order.
REQ-039 adc rising with nre1=nre2=0 -> no push; proto_err=1 with PIXEL_PROTOCOL_CHECK_EN, 0 without.
REQ-040 reset asserted in PUSH1 with 3 words buffered -> next cycle pix_valid=0, FIFO empty, state IDLE, accumulators 0.
REQ-041 erase and expose both high, light 0x20 -> accumulators stay 0.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and constants for the 2x2 pixel array readout.
package pixel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH0 = 2'd1,
    PUSH1 = 2'd2
  } seq_state_t;

  localparam int PIX_W_DEF      = 8;
  localparam int ACC_W_DEF      = 12;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int NUM_ROWS = 2;
  localparam int NUM_COLS = 2;
  localparam int NUM_PIX  = NUM_ROWS * NUM_COLS;

  // Pixel k sits at k = 2*row + col.
  localparam int PIX_R0C0 = 0;
  localparam int PIX_R0C1 = 1;
  localparam int PIX_R1C0 = 2;
  localparam int PIX_R1C1 = 3;

  function automatic logic [1:0] pix_index(input logic row, input logic col);
    return {row, col};
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// Synchronous output buffer with full/empty flags and same-cycle push/pop.
module readout_fifo
  import pixel_pkg::*;
#(
  parameter int WIDTH = PIX_W_DEF + 2,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A pop frees a slot in the same cycle, so a full buffer still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/pixel_array_readout.sv
// 2x2 pixel array: saturating charge integration, row readout sequencer, output buffer.
// Optional protocol checker enabled by defining PIXEL_PROTOCOL_CHECK_EN.
module pixel_array_readout
  import pixel_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   erase,
  input  logic                   expose,
  input  logic                   nre1,
  input  logic                   nre2,
  input  logic                   adc,
  input  logic [4*PIX_W-1:0]     light,
  output logic [PIX_W+1:0]       pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   proto_err
);

  logic [ACC_W-1:0] acc_reg [NUM_PIX];

  generate
    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_pix
      logic [PIX_W-1:0] light_k;
      logic [ACC_W:0]   sum_k;

      assign light_k = light[gi*PIX_W +: PIX_W];
      assign sum_k   = {1'b0, acc_reg[gi]} + (ACC_W+1)'(light_k);

      always_ff @(posedge clk) begin
        if (reset || erase) begin
          acc_reg[gi] <= '0;
        end else if (expose) begin
          acc_reg[gi] <= sum_k[ACC_W] ? {ACC_W{1'b1}} : sum_k[ACC_W-1:0];
        end
      end
    end
  endgenerate

  seq_state_t state_reg;
  seq_state_t state_next;
  logic       row_reg;
  logic       row_next;
  logic       adc_prev_reg;
  logic       adc_rise;
  logic       one_row;
  logic       push;
  logic       push_col;

  assign adc_rise = adc & ~adc_prev_reg;
  assign one_row  = nre1 ^ nre2;

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    push       = 1'b0;
    push_col   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (adc_rise && one_row) begin
          state_next = PUSH0;
          // Only one enable is low here: nre1 high means row 1 was selected.
          row_next   = nre1;
        end
      end
      PUSH0: begin
        push       = 1'b1;
        push_col   = 1'b0;
        state_next = PUSH1;
      end
      PUSH1: begin
        push       = 1'b1;
        push_col   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      row_reg      <= 1'b0;
      adc_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      adc_prev_reg <= adc;
    end
  end

  logic [PIX_W-1:0] push_code;
  logic [PIX_W+1:0] push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_fire;
  logic             drop;

  assign push_code = acc_reg[pix_index(row_reg, push_col)][ACC_W-1 -: PIX_W];
  assign push_data = {row_reg, push_col, push_code};
  assign pop_fire  = pix_valid & pix_ready;
  assign drop      = push & fifo_full & ~pop_fire;

  readout_fifo #(
    .WIDTH (PIX_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pix_ready),
    .pop_data  (pix_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;

  logic frame_done_reg;
  logic overrun_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      // Fires after the row-1 col-1 push cycle whether or not the word fit.
      frame_done_reg <= (state_reg == PUSH1) && row_reg;
      overrun_reg    <= overrun_reg | drop;
    end
  end

  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

`ifdef PIXEL_PROTOCOL_CHECK_EN
  logic proto_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
    end else begin
      proto_err_reg <= proto_err_reg
                     | (~nre1 & ~nre2)
                     | (expose & erase)
                     | (adc & nre1 & nre2)
                     | (expose & adc);
    end
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_array_readout.sv
// Directed self-checking bench for pixel_array_readout.
module tb_pixel_array_readout;

  localparam int PIX_W = 8;
  localparam int ACC_W = 12;
  localparam int FIFO_DEPTH = 4;

  logic               clk;
  logic               reset;
  logic               erase;
  logic               expose;
  logic               nre1;
  logic               nre2;
  logic               adc;
  logic [4*PIX_W-1:0] light;
  logic [PIX_W+1:0]   pix_data;
  logic               pix_valid;
  logic               pix_ready;
  logic               frame_done;
  logic               overrun;
  logic               proto_err;

  int compared;
  int mismatched;
  int fd_count;
  logic [PIX_W+1:0] words[$];

  pixel_array_readout #(
    .PIX_W      (PIX_W),
    .ACC_W      (ACC_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .erase      (erase),
    .expose     (expose),
    .nre1       (nre1),
    .nre2       (nre2),
    .adc        (adc),
    .light      (light),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done),
    .overrun    (overrun),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record transfers and frame_done pulses mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      words.push_back(pix_data);
      $display("xfer: data=%h", pix_data);
    end
    if (frame_done) fd_count++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic read_row(input logic row);
    nre1 = row;
    nre2 = ~row;
    adc  = 1'b1;
    tick(1);
    adc  = 1'b0;
    nre1 = 1'b1;
    nre2 = 1'b1;
    tick(4);
  endtask

  task automatic load(input logic [4*PIX_W-1:0] l, input int cycles);
    erase = 1'b1;
    tick(1);
    erase  = 1'b0;
    light  = l;
    expose = 1'b1;
    tick(cycles);
    expose = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared += 4;
    if (pix_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    if (proto_err !== 1'b0) begin mismatched++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    $display("test_reset done");
  endtask

  task automatic test_frame();
    logic [PIX_W+1:0] exp_w [4];
    exp_w[0] = 10'h00F; exp_w[1] = 10'h10F; exp_w[2] = 10'h20F; exp_w[3] = 10'h30F;
    do_reset();
    pix_ready = 1'b1;
    load({4{8'h10}}, 15);
    words.delete();
    fd_count = 0;
    read_row(1'b0);
    compared++;
    if (fd_count !== 0) begin mismatched++; $display("FAIL frame_row0_fd: got %0d want 0", fd_count); end
    read_row(1'b1);
    compared += 2;
    if (fd_count !== 1) begin mismatched++; $display("FAIL frame_fd_count: got %0d want 1", fd_count); end
    if (words.size() !== 4) begin
      mismatched++; $display("FAIL frame_word_count: got %0d want 4", words.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (words[i] !== exp_w[i]) begin mismatched++; $display("FAIL frame_word%0d: got %h want %h", i, words[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    words.delete();
    load({24'h0, 8'hFF}, 30);
    read_row(1'b0);
    compared += 3;
    if (words.size() !== 2) begin mismatched++; $display("FAIL sat_word_count: got %0d want 2", words.size()); end
    if (words.size() >= 1 && words[0] !== 10'h0FF) begin mismatched++; $display("FAIL sat_code: got %h want 0ff", words[0]); end
    if (words.size() >= 2 && words[1] !== 10'h100) begin mismatched++; $display("FAIL sat_neighbour: got %h want 100", words[1]); end
  endtask

  task automatic test_overrun();
    logic [PIX_W+1:0] exp_w [4];
    int fd_before;
    exp_w[0] = 10'h010; exp_w[1] = 10'h120; exp_w[2] = 10'h230; exp_w[3] = 10'h340;
    do_reset();
    load({8'h40, 8'h30, 8'h20, 8'h10}, 16);
    pix_ready = 1'b0;
    words.delete();
    fd_before = fd_count;
    read_row(1'b0);
    read_row(1'b1);
    compared += 3;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL ovr_full_no_drop: got %b want 0", overrun); end
    if (pix_valid !== 1'b1) begin mismatched++; $display("FAIL ovr_valid: got %b want 1", pix_valid); end
    if (pix_data !== 10'h010) begin mismatched++; $display("FAIL ovr_head_stable: got %h want 010", pix_data); end
    read_row(1'b0);
    compared += 3;
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    if (fd_count - fd_before !== 1) begin mismatched++; $display("FAIL ovr_fd_count: got %0d want 1", fd_count - fd_before); end
    if (pix_data !== 10'h010) begin mismatched++; $display("FAIL ovr_head_after_drop: got %h want 010", pix_data); end
    pix_ready = 1'b1;
    tick(6);
    compared += 2;
    if (pix_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_drained: got %b want 0", pix_valid); end
    if (words.size() !== 4) begin
      mismatched++; $display("FAIL ovr_word_count: got %0d want 4", words.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (words[i] !== exp_w[i]) begin mismatched++; $display("FAIL ovr_word%0d: got %h want %h", i, words[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PIX_W+1:0] exp_w [6];
    exp_w[0] = 10'h010; exp_w[1] = 10'h120; exp_w[2] = 10'h230;
    exp_w[3] = 10'h340; exp_w[4] = 10'h010; exp_w[5] = 10'h120;
    do_reset();
    load({8'h40, 8'h30, 8'h20, 8'h10}, 16);
    pix_ready = 1'b0;
    words.delete();
    read_row(1'b0);
    read_row(1'b1);
    // Pop exactly during the two push cycles of a row-0 read into a full buffer.
    nre1 = 1'b0;
    nre2 = 1'b1;
    adc  = 1'b1;
    tick(1);
    adc  = 1'b0;
    nre1 = 1'b1;
    pix_ready = 1'b1;
    tick(2);
    pix_ready = 1'b0;
    tick(2);
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    pix_ready = 1'b1;
    tick(6);
    if (words.size() !== 6) begin
      compared++; mismatched++; $display("FAIL b2b_word_count: got %0d want 6", words.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        compared++;
        if (words[i] !== exp_w[i]) begin mismatched++; $display("FAIL b2b_word%0d: got %h want %h", i, words[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int fd_before;
    pix_ready = 1'b0;
    read_row(1'b0);
    nre1 = 1'b1;
    nre2 = 1'b0;
    adc  = 1'b1;
    tick(1);
    adc  = 1'b0;
    nre2 = 1'b1;
    tick(1);
    fd_before = fd_count;
    reset = 1'b1;
    tick(1);
    compared += 3;
    if (pix_valid !== 1'b0) begin mismatched++; $display("FAIL mid_reset_valid: got %b want 0", pix_valid); end
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL mid_reset_fd: got %b want 0", frame_done); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL mid_reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
    pix_ready = 1'b1;
    words.delete();
    tick(4);
    compared += 2;
    if (words.size() !== 0) begin mismatched++; $display("FAIL mid_reset_leftover: got %0d want 0", words.size()); end
    if (fd_count !== fd_before) begin mismatched++; $display("FAIL mid_reset_fd_pulse: got %0d want %0d", fd_count, fd_before); end
    read_row(1'b1);
    compared += 2;
    if (words.size() >= 1 && words[0] !== 10'h200) begin mismatched++; $display("FAIL mid_reset_acc0: got %h want 200", words[0]); end
    if (words.size() !== 2 || words[1] !== 10'h300) begin mismatched++; $display("FAIL mid_reset_acc1: got %0d words want 2 ending 300", words.size()); end
  endtask

  task automatic test_protocol();
    logic exp_proto;
`ifdef PIXEL_PROTOCOL_CHECK_EN
    exp_proto = 1'b1;
`else
    exp_proto = 1'b0;
`endif
    do_reset();
    load({4{8'h10}}, 16);
    pix_ready = 1'b1;
    words.delete();
    compared++;
    if (proto_err !== 1'b0) begin mismatched++; $display("FAIL proto_clean: got %b want 0", proto_err); end
    nre1 = 1'b0;
    nre2 = 1'b0;
    adc  = 1'b1;
    tick(1);
    adc  = 1'b0;
    nre1 = 1'b1;
    nre2 = 1'b1;
    tick(4);
    compared += 3;
    if (words.size() !== 0) begin mismatched++; $display("FAIL proto_both_low_push: got %0d want 0", words.size()); end
    if (pix_valid !== 1'b0) begin mismatched++; $display("FAIL proto_valid: got %b want 0", pix_valid); end
    if (proto_err !== exp_proto) begin mismatched++; $display("FAIL proto_err: got %b want %b", proto_err, exp_proto); end
    adc = 1'b1;
    tick(1);
    adc = 1'b0;
    tick(4);
    compared++;
    if (words.size() !== 0) begin mismatched++; $display("FAIL proto_both_high_push: got %0d want 0", words.size()); end
  endtask

  task automatic test_erase_priority();
    do_reset();
    load({4{8'h10}}, 16);
    pix_ready = 1'b1;
    words.delete();
    light  = {4{8'h20}};
    erase  = 1'b1;
    expose = 1'b1;
    tick(5);
    erase  = 1'b0;
    expose = 1'b0;
    read_row(1'b0);
    compared += 2;
    if (words.size() !== 2) begin mismatched++; $display("FAIL erase_word_count: got %0d want 2", words.size()); end
    if (words.size() >= 2 && (words[0] !== 10'h000 || words[1] !== 10'h100))
      begin mismatched++; $display("FAIL erase_prio: got %h %h want 000 100", words[0], words[1]); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    fd_count   = 0;
    reset      = 1'b1;
    erase      = 1'b0;
    expose     = 1'b0;
    nre1       = 1'b1;
    nre2       = 1'b1;
    adc        = 1'b0;
    light      = '0;
    pix_ready  = 1'b0;
    test_reset();
    test_frame();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_erase_priority();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
